// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state encoding, client ids and default sizes for the SRAM arbiter
package sram_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int TIMEOUT_CYC_DEF = 16;
endpackage

// File: rtl/sram_arb_grant.sv
// sram_arb_grant: winner select between two clients; SRAM_ARB_ROUND_ROBIN_EN selects round-robin, otherwise c0 has fixed priority
module sram_arb_grant
    import sram_arb_pkg::*;
(
    input  logic c0_req,
    input  logic c1_req,
    input  logic owner,
    output logic grant
);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    assign grant = (c0_req && c1_req) ? ~owner : c0_req ? CLIENT0 : c1_req ? CLIENT1 : owner;
`else
    assign grant = c0_req ? CLIENT0 : c1_req ? CLIENT1 : owner;
`endif
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: serialises two clients onto one SRAM controller with a WAIT watchdog; SRAM_ARB_ROUND_ROBIN_EN enables round-robin grant
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c0_read_en,
    input  logic              c0_write_en,
    input  logic [ADDR_W-1:0] c0_address,
    input  logic [DATA_W-1:0] c0_write_data,
    output logic [DATA_W-1:0] c0_read_data,
    output logic              c0_ready,
    output logic              c0_done,
    input  logic              c1_read_en,
    input  logic              c1_write_en,
    input  logic [ADDR_W-1:0] c1_address,
    input  logic [DATA_W-1:0] c1_write_data,
    output logic [DATA_W-1:0] c1_read_data,
    output logic              c1_ready,
    output logic              c1_done,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              owner,
    output logic              err
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic c0_req, c1_req, grant, start, timeout, finish;
    assign c0_req   = c0_read_en | c0_write_en;
    assign c1_req   = c1_read_en | c1_write_en;
    assign c0_ready = ~c0_req | c0_done;
    assign c1_ready = ~c1_req | c1_done;
    // the done cycle still shows the completed request, so no grant is made while a done pulse is out
    assign start    = (state == IDLE) && (c0_req || c1_req) && !(c0_done || c1_done);
    assign timeout  = cnt == CNT_W'(TIMEOUT_CYC - 1);
    assign finish   = (state == WAIT) && (mem_ready || timeout);
    sram_arb_grant u_grant (
        .c0_req (c0_req),
        .c1_req (c1_req),
        .owner  (owner),
        .grant  (grant)
    );
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // next-state: one issue cycle, wait for ready or watchdog, one quiet done cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = finish ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    // request latch, memory strobes, read-data return, done pulses and watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_en    <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            c0_read_data   <= '0;
            c1_read_data   <= '0;
            c0_done        <= 1'b0;
            c1_done        <= 1'b0;
            owner          <= CLIENT1;
            err            <= 1'b0;
            cnt            <= '0;
        end else begin
            c0_done <= (state == DONE) && (owner == CLIENT0);
            c1_done <= (state == DONE) && (owner == CLIENT1);
            if (start) begin
                owner          <= grant;
                mem_write_en   <= grant ? c1_write_en : c0_write_en;
                mem_read_en    <= grant ? ~c1_write_en : ~c0_write_en;
                mem_address    <= grant ? c1_address : c0_address;
                mem_write_data <= grant ? c1_write_data : c0_write_data;
            end
            if (state == WAIT) cnt <= cnt + CNT_W'(1);
            if (state == DONE) cnt <= '0;
            if (finish) begin
                mem_read_en  <= 1'b0;
                mem_write_en <= 1'b0;
            end
            if (state == WAIT && mem_ready && mem_read_en && owner == CLIENT0) c0_read_data <= mem_read_data;
            if (state == WAIT && mem_ready && mem_read_en && owner == CLIENT1) c1_read_data <= mem_read_data;
            if (state == WAIT && timeout && !mem_ready) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vector table plus hand sequences for arbitration, watchdog and async reset
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c0_read_en = 1'b0, c0_write_en = 1'b0, c1_read_en = 1'b0, c1_write_en = 1'b0;
    logic [31:0] c0_address = '0, c0_write_data = '0, c1_address = '0, c1_write_data = '0;
    logic [31:0] c0_read_data, c1_read_data, mem_address, mem_write_data, mem_read_data;
    logic        c0_ready, c0_done, c1_ready, c1_done, mem_read_en, mem_write_en, mem_ready, owner, err;
    logic        mem_en, en_prev = 1'b0;
    logic [31:0] a_prev = '0, w_prev = '0, rdata = '0;
    int cyc = 0, en_cnt = 0, lat = 7;
    int en_total = 0, wr_total = 0, d0_total = 0, d1_total = 0, chg_total = 0;
    int total = 0, bad = 0;

    typedef struct {
        bit          client;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        int          exp_delta;
        int          exp_en;
        int          exp_wr;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        bit          exp_err;
    } vec_t;
    vec_t vecs[6];
    vec_t v_extra;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .c0_read_en(c0_read_en), .c0_write_en(c0_write_en), .c0_address(c0_address),
        .c0_write_data(c0_write_data), .c0_read_data(c0_read_data), .c0_ready(c0_ready), .c0_done(c0_done),
        .c1_read_en(c1_read_en), .c1_write_en(c1_write_en), .c1_address(c1_address),
        .c1_write_data(c1_write_data), .c1_read_data(c1_read_data), .c1_ready(c1_ready), .c1_done(c1_done),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_ready(mem_ready), .mem_read_data(mem_read_data),
        .owner(owner), .err(err)
    );

    assign mem_en        = mem_read_en | mem_write_en;
    assign mem_ready     = mem_en && (en_cnt == lat);
    assign mem_read_data = rdata;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        en_cnt    <= mem_en ? en_cnt + 1 : 0;
        en_total  <= en_total + int'(mem_en);
        wr_total  <= wr_total + int'(mem_write_en);
        d0_total  <= d0_total + int'(c0_done);
        d1_total  <= d1_total + int'(c1_done);
        if (en_prev && mem_en && (mem_address != a_prev || mem_write_data != w_prev)) chg_total <= chg_total + 1;
        en_prev <= mem_en;
        a_prev  <= mem_address;
        w_prev  <= mem_write_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit cl, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (cl) begin
            c1_read_en = rd; c1_write_en = wr; c1_address = a; c1_write_data = d;
        end else begin
            c0_read_en = rd; c0_write_en = wr; c0_address = a; c0_write_data = d;
        end
    endtask

    task automatic wait_done(input bit cl, input string nm);
        for (int i = 0; i < 60 && !(cl ? c1_done : c0_done); i++) @(negedge clk);
        chk({nm, "_done_seen"}, 32'(cl ? c1_done : c0_done), 32'd1);
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int t0, e0, w0, ch0, od0, md0;
        @(negedge clk);
        lat = v.lat;
        rdata = v.rdata;
        drive(v.client, v.rd, v.wr, v.addr, v.wdata);
        t0 = cyc; e0 = en_total; w0 = wr_total; ch0 = chg_total;
        od0 = v.client ? d0_total : d1_total;
        md0 = v.client ? d1_total : d0_total;
        @(negedge clk);
        chk({nm, "_ready_busy"}, 32'(v.client ? c1_ready : c0_ready), 32'd0);
        wait_done(v.client, nm);
        chk({nm, "_latency"}, 32'(cyc - t0), 32'(v.exp_delta));
        chk({nm, "_ready_done"}, 32'(v.client ? c1_ready : c0_ready), 32'd1);
        chk({nm, "_owner"}, 32'(owner), 32'(v.client));
        chk({nm, "_addr"}, mem_address, v.addr);
        if (v.wr) chk({nm, "_wdata"}, mem_write_data, v.wdata);
        chk({nm, "_rd0"}, c0_read_data, v.exp_rd0);
        chk({nm, "_rd1"}, c1_read_data, v.exp_rd1);
        chk({nm, "_err"}, 32'(err), 32'(v.exp_err));
        drive(v.client, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk({nm, "_en_cycles"}, 32'(en_total - e0), 32'(v.exp_en));
        chk({nm, "_wr_cycles"}, 32'(wr_total - w0), 32'(v.exp_wr));
        chk({nm, "_bus_stable"}, 32'(chg_total - ch0), 32'd0);
        chk({nm, "_done_pulses"}, 32'((v.client ? d1_total : d0_total) - md0), 32'd1);
        chk({nm, "_other_done"}, 32'((v.client ? d0_total : d1_total) - od0), 32'd0);
    endtask

    initial begin
        int t0;
        //          cl  rd  wr  addr           wdata          lat  rdata          dly en  wr  rd0            rd1            err
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0410, 32'h0, 7, 32'hDEAD_BEEF, 10, 8, 0, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678, 7, 32'hFFFF_FFFF, 10, 8, 8, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 3, 32'hCAFE_F00D, 6, 4, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0804, 32'h0000_A5A5, 2, 32'h9999_9999, 5, 3, 3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0420, 32'h0, 255, 32'h1111_1111, 19, 17, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0424, 32'h0, 1, 32'h0000_55AA, 4, 2, 0, 32'h0000_55AA, 32'hCAFE_F00D, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_mem_read_en", 32'(mem_read_en), 32'd0);
        chk("rst_mem_write_en", 32'(mem_write_en), 32'd0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_write_data", mem_write_data, 32'h0);
        chk("rst_c0_done", 32'(c0_done), 32'd0);
        chk("rst_c1_done", 32'(c1_done), 32'd0);
        chk("rst_c0_read_data", c0_read_data, 32'h0);
        chk("rst_c1_read_data", c1_read_data, 32'h0);
        chk("rst_owner", 32'(owner), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_c0_ready", 32'(c0_ready), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // both clients request in the same cycle: c0 first, c1 follows 4+N cycles after c0_done
        @(negedge clk);
        lat = 7;
        rdata = 32'hA0A0_A0A0;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        t0 = cyc;
        wait_done(1'b0, "both_c0");
        chk("both_c0_latency", 32'(cyc - t0), 32'd10);
        chk("both_c0_owner", 32'(owner), 32'd0);
        chk("both_c0_rd0", c0_read_data, 32'hA0A0_A0A0);
        chk("both_c1_held", 32'(c1_ready), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rdata = 32'hB1B1_B1B1;
        t0 = cyc;
        wait_done(1'b1, "both_c1");
        chk("both_c1_gap", 32'(cyc - t0), 32'd11);
        chk("both_c1_owner", 32'(owner), 32'd1);
        chk("both_c1_addr", mem_address, 32'h20);
        chk("both_c1_rd1", c1_read_data, 32'hB1B1_B1B1);
        chk("both_c1_rd0_kept", c0_read_data, 32'hA0A0_A0A0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        v_extra = '{1'b1, 1'b1, 1'b0, 32'h0000_0024, 32'h0, 4, 32'hC3C3_C3C3, 7, 5, 0, 32'hA0A0_A0A0, 32'hC3C3_C3C3, 1'b1};
        run_txn(v_extra, "c1_again");

        // asynchronous reset in the middle of a c1 write
        @(negedge clk);
        lat = 7;
        drive(1'b1, 1'b0, 1'b1, 32'h30, 32'h77);
        repeat (4) @(negedge clk);
        chk("arst_pre_write_en", 32'(mem_write_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_write_en", 32'(mem_write_en), 32'd0);
        chk("arst_read_en", 32'(mem_read_en), 32'd0);
        chk("arst_c1_done", 32'(c1_done), 32'd0);
        chk("arst_owner", 32'(owner), 32'd1);
        chk("arst_addr", mem_address, 32'h0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_rd1", c1_read_data, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        v_extra = '{1'b0, 1'b1, 1'b0, 32'h0000_0440, 32'h0, 7, 32'h600D_F00D, 10, 8, 0, 32'h600D_F00D, 32'h0, 1'b0};
        run_txn(v_extra, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
